// File: rtl/ntt_radix_in_gather.sv
// Gathers C-coefficient beats into one R-coefficient group, applies the optional bit-reversed
// input permutation, and presents the group on a registered valid/ready output with framing tags.
module ntt_radix_in_gather #(
  parameter int R       = 8,
  parameter int C       = 2,
  parameter int OP_W    = 64,
  parameter int BIT_REV = 1
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic [C*OP_W-1:0] in_data,
  input  logic              in_sob,
  input  logic              in_eob,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [R*OP_W-1:0] out_data,
  output logic              out_sob,
  output logic              out_eob,
  output logic              out_avail,
  input  logic              out_rdy,
  output logic              out_err
);

  localparam int NB    = R / C;
  localparam int LOG_R = $clog2(R);
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);

  function automatic int bitrev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < LOG_R; b++) begin
      if (v[b]) r = r | (1 << (LOG_R - 1 - b));
    end
    return r;
  endfunction

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, eff_cnt;
  logic [OP_W-1:0]  gather_q [R];
  logic [OP_W-1:0]  merged   [R];
  logic [R*OP_W-1:0] group_perm;
  logic             grp_sob_q, grp_sob_d;
  logic [R*OP_W-1:0] out_data_q, out_data_d;
  logic             out_sob_q, out_sob_d;
  logic             out_eob_q, out_eob_d;
  logic             out_avail_q, out_avail_d;
  logic             out_err_q, out_err_d;
  logic             last_beat, accept, err_sob, err_eob, keep_beat, closing;

  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign in_rdy    = ~last_beat | ~out_avail_q | out_rdy;
  assign accept    = in_vld & in_rdy;
  // eob error takes priority: the beat is dropped and the counter restarts.
  assign err_eob   = accept & in_eob & ~last_beat;
  assign err_sob   = accept & in_sob & (beat_cnt_q != '0) & ~err_eob;
  assign eff_cnt   = err_sob ? '0 : beat_cnt_q;
  assign keep_beat = accept & ~err_eob;
  assign closing   = keep_beat & (eff_cnt == LAST_BEAT);

  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_slot
      localparam int SRC = (BIT_REV != 0) ? bitrev(gi) : gi;
      assign merged[gi] = (keep_beat && eff_cnt == CNT_W'(gi / C))
                          ? in_data[(gi % C)*OP_W +: OP_W] : gather_q[gi];
      assign group_perm[gi*OP_W +: OP_W] = merged[SRC];
    end
  endgenerate

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    grp_sob_d   = grp_sob_q;
    out_data_d  = out_data_q;
    out_sob_d   = out_sob_q;
    out_eob_d   = out_eob_q;
    out_avail_d = out_avail_q;
    out_err_d   = err_sob | err_eob;
    if (accept) begin
      if (err_eob || closing) beat_cnt_d = '0;
      else                    beat_cnt_d = eff_cnt + 1'b1;
    end
    if (keep_beat && eff_cnt == '0) grp_sob_d = in_sob;
    if (out_avail_q && out_rdy) out_avail_d = 1'b0;
    if (closing) begin
      out_data_d  = group_perm;
      out_sob_d   = (eff_cnt == '0) ? in_sob : grp_sob_q;
      out_eob_d   = in_eob;
      out_avail_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      beat_cnt_q  <= '0;
      grp_sob_q   <= 1'b0;
      out_data_q  <= '0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_avail_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      grp_sob_q   <= grp_sob_d;
      out_data_q  <= out_data_d;
      out_sob_q   <= out_sob_d;
      out_eob_q   <= out_eob_d;
      out_avail_q <= out_avail_d;
      out_err_q   <= out_err_d;
    end
  end

  // Slot storage carries no reset; a partial group is discarded by restarting the counter.
  always_ff @(posedge clk) begin
    for (int j = 0; j < R; j++) gather_q[j] <= merged[j];
  end

  assign out_data  = out_data_q;
  assign out_sob   = out_sob_q;
  assign out_eob   = out_eob_q;
  assign out_avail = out_avail_q;
  assign out_err   = out_err_q;

endmodule
